// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and defaults for the unified memory arbiter.
// Holds the arbiter state encoding, the memory word width and the default tuning parameters.
package unified_mem_arbiter_pkg;

    localparam int WORD_W              = 32;
    localparam int DEF_MAX_DATA_STREAK = 4;
    localparam int DEF_TIMEOUT_CYCLES  = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_BUSY = 3'd1,
        D_DONE = 3'd2,
        F_BUSY = 3'd3,
        F_DONE = 3'd4
    } arb_state_e;

endpackage

// File: rtl/unified_mem_arbiter_watchdog.sv
// Counts consecutive BUSY cycles of one memory access; expire is high in the last allowed cycle.
// The count restarts whenever the arbiter changes state or leaves the BUSY states.
module arb_watchdog
    import unified_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    input  logic clr,
    output logic expire
);

    localparam int               CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!busy || clr) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = busy && (cnt_q == LAST);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and the MEM stage.
// MEM wins unless fetch has been starved for MAX_DATA_STREAK grants; any pending access freezes the pipeline.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              MemToRegM,
    input  logic              MemWriteM,
    input  logic [WORD_W-1:0] ALUOutM,
    input  logic [WORD_W-1:0] WriteDataM,
    output logic [WORD_W-1:0] ReadDataM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushW,
    output logic              err
);

    localparam int                  STREAK_W   = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    arb_state_e          state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [WORD_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [WORD_W-1:0]   if_rdata_q, if_rdata_d;
    logic                if_valid_q, if_valid_d;
    logic [WORD_W-1:0]   read_data_q, read_data_d;
    logic                err_q, err_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic data_pending;
    logic streak_full;
    logic wd_busy;
    logic wd_clr;
    logic wd_expire;
    logic stall;

    assign data_pending = MemToRegM | MemWriteM;
    assign streak_full  = (streak_q == STREAK_MAX);
    assign wd_busy      = (state_q == D_BUSY) || (state_q == F_BUSY);
    assign wd_clr       = (state_d != state_q);

    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .busy   (wd_busy),
        .clr    (wd_clr),
        .expire (wd_expire)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        if_valid_d  = 1'b0;
        read_data_d = read_data_q;
        err_d       = err_q;
        streak_d    = streak_q;

        case (state_q)
            IDLE: begin
                // Fetch only overrides a pending data access once it has lost MAX_DATA_STREAK times in a row.
                if (data_pending && !(if_req && streak_full)) begin
                    state_d     = D_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWriteM;
                    mem_addr_d  = ALUOutM;
                    mem_wdata_d = WriteDataM;
                end else if (if_req) begin
                    state_d    = F_BUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                end
            end
            D_BUSY: begin
                if (mem_ready) begin
                    state_d   = D_DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        read_data_d = mem_rdata;
                    end
                    if (if_req) begin
                        streak_d = streak_full ? streak_q : streak_q + STREAK_W'(1);
                    end else begin
                        streak_d = '0;
                    end
                end else if (wd_expire) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                end
            end
            F_BUSY: begin
                if (mem_ready) begin
                    state_d    = F_DONE;
                    mem_req_d  = 1'b0;
                    if_rdata_d = mem_rdata;
                    if_valid_d = 1'b1;
                    streak_d   = '0;
                end else if (wd_expire) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                end
            end
            D_DONE:  state_d = IDLE;
            F_DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            read_data_q <= '0;
            err_q       <= 1'b0;
            streak_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            read_data_q <= read_data_d;
            err_q       <= err_d;
            streak_q    <= streak_d;
        end
    end

    // D_DONE releases everything for one cycle so the MEM stage can retire its access.
    assign stall = (data_pending && (state_q != D_DONE))
                || (if_req && (state_q != F_DONE) && (state_q != D_DONE));

    assign StallF    = stall;
    assign StallD    = stall;
    assign StallE    = stall;
    assign StallM    = stall;
    assign FlushW    = stall;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign ReadDataM = read_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomised bench for unified_mem_arbiter: a transaction-level reference model predicts grants,
// results, stalls and timeouts; a negedge monitor pops the expectations as the DUT presents them.
module tb_unified_mem_arbiter;

    localparam int MAXS = 4;
    localparam int TO   = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        MemToRegM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [31:0] ALUOutM = '0;
    logic [31:0] WriteDataM = '0;
    logic [31:0] ReadDataM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        StallF, StallD, StallE, StallM, FlushW;
    logic        err;

    always #5 clk = ~clk;

    unified_mem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_valid   (if_valid),
        .MemToRegM  (MemToRegM),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushW     (FlushW),
        .err        (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [31:0] fetch_q[$];

    // m_done: 0 none, 1 data just finished, 2 fetch just finished
    bit          m_busy   = 0;
    bit          m_isdata = 0;
    bit          m_load   = 0;
    int          m_done   = 0;
    int          m_age    = 0;
    int          m_streak = 0;
    bit          m_err    = 0;
    logic [31:0] m_rd     = '0;
    int          n_fetch_by_streak = 0;
    logic        dp_s;
    req_t        new_r;

    always @(posedge clk) begin
        dp_s = MemToRegM | MemWriteM;
        if (!reset) begin
            m_busy = 0; m_done = 0; m_age = 0; m_streak = 0; m_err = 0; m_rd = '0;
            req_q.delete();
            fetch_q.delete();
        end else if (m_done != 0) begin
            m_done = 0;
        end else if (m_busy) begin
            if (mem_ready) begin
                m_busy = 0;
                if (m_isdata) begin
                    if (m_load) m_rd = mem_rdata;
                    m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
                    m_done = 1;
                end else begin
                    fetch_q.push_back(mem_rdata);
                    m_streak = 0;
                    m_done = 2;
                end
            end else if (m_age == TO - 1) begin
                m_busy = 0;
                m_err  = 1;
            end else begin
                m_age++;
            end
        end else if (dp_s && !(if_req && m_streak == MAXS)) begin
            m_busy = 1; m_isdata = 1; m_age = 0; m_load = !MemWriteM;
            new_r.addr = ALUOutM; new_r.we = MemWriteM; new_r.wdata = WriteDataM;
            req_q.push_back(new_r);
        end else if (if_req) begin
            if (dp_s) n_fetch_by_streak++;
            m_busy = 1; m_isdata = 0; m_age = 0;
            new_r.addr = if_addr; new_r.we = 1'b0; new_r.wdata = '0;
            req_q.push_back(new_r);
        end
    end

    // ---------------- monitor ----------------
    logic prev_req   = 1'b0;
    logic last_stall = 1'b0;
    logic exp_stall;
    req_t got_r;

    always @(negedge clk) begin
        #2;
        exp_stall = ((MemToRegM | MemWriteM) && m_done != 1) || (if_req && m_done == 0);
        check("stall", {StallF, StallD, StallE, StallM, FlushW}, {5{exp_stall}});
        check("mem_req", mem_req, m_busy);
        check("if_valid", if_valid, m_done == 2);
        check("ReadDataM", ReadDataM, m_rd);
        check("err", err, m_err);
        if (mem_req && !prev_req) begin
            if (req_q.size() == 0) begin
                check("req_unexpected", 1, 0);
            end else begin
                got_r = req_q.pop_front();
                check("mem_addr", mem_addr, got_r.addr);
                check("mem_we", mem_we, got_r.we);
                if (got_r.we) check("mem_wdata", mem_wdata, got_r.wdata);
            end
        end
        if (if_valid) begin
            if (fetch_q.size() == 0) check("fetch_unexpected", 1, 0);
            else check("if_rdata", if_rdata, fetch_q.pop_front());
        end
        prev_req   = mem_req;
        last_stall = StallM;
    end

    // ---------------- stimulus ----------------
    int lat_max  = 3;
    bit spur     = 1;
    int data_pct = 70;
    int if_pct   = 80;
    int resp_cnt = -1;
    int r;

    task automatic step();
        @(negedge clk);
        if (!last_stall) begin
            r = $urandom_range(0, 99);
            MemToRegM  = (r < data_pct / 2);
            MemWriteM  = (r >= data_pct / 2) && (r < data_pct);
            ALUOutM    = 32'h2000_0000 | ($urandom & 32'h0000_FFFC);
            WriteDataM = $urandom;
            if_req     = ($urandom_range(0, 99) < if_pct);
            if_addr    = 32'h1000_0000 | ($urandom & 32'h0000_FFFC);
        end
        if (mem_req) begin
            if (resp_cnt < 0) resp_cnt = $urandom_range(0, lat_max);
            if (resp_cnt == 0) begin
                mem_ready = 1'b1;
            end else begin
                mem_ready = 1'b0;
                resp_cnt--;
            end
        end else begin
            resp_cnt  = -1;
            mem_ready = spur && ($urandom_range(0, 3) == 0);
        end
        mem_rdata = $urandom;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_if_rdata"}, if_rdata, 0);
        check({tag, "_if_valid"}, if_valid, 0);
        check({tag, "_ReadDataM"}, ReadDataM, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        #3 check_cleared("reset");
        reset = 1'b1;

        // mixed traffic with short random latency and stray ready pulses
        repeat (400) step();

        // fetch against a continuous data stream: starvation limit must hand fetch a turn
        data_pct = 100; if_pct = 100;
        repeat (300) step();
        check("starve_fetch_seen", n_fetch_by_streak > 0, 1);

        // memory hangs: every access times out and is re-arbitrated
        data_pct = 70; if_pct = 80; lat_max = 100000;
        repeat (200) step();
        check("timeout_err", err, 1);

        // memory recovers; err stays sticky
        lat_max = 5;
        repeat (200) step();
        check("err_sticky", err, 1);

        // reset while an access is in flight, followed by a late ready
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (mem_req) found = 1;
        end
        check("rst_found_busy", found, 1);
        reset = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b1;
        MemToRegM = 1'b0; MemWriteM = 1'b0; if_req = 1'b0;
        #3 check_cleared("midrst");
        @(negedge clk);
        #3 check("late_ready_ignored", {mem_req, if_valid}, 2'b00);

        lat_max = 3;
        repeat (300) step();

        // drain and confirm every predicted response was observed
        data_pct = 0; if_pct = 0; spur = 0;
        repeat (100) step();
        check("req_q_empty", req_q.size(), 0);
        check("fetch_q_empty", fetch_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
